// File: rtl/d_ext_pipe_if.sv
// d_ext_pipe_if: D-stage immediate request and registered D->E extender result
interface d_ext_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             stall;
  logic             flush;
  logic             in_valid;
  logic [IN_W-1:0]  offset;
  logic [2:0]       ext_op;
  logic             out_valid;
  logic [OUT_W-1:0] sign_imm;
  logic [2:0]       out_op;
  logic             op_err;
  modport master (
    output stall, flush, in_valid, offset, ext_op,
    input  out_valid, sign_imm, out_op, op_err
  );
  modport slave (
    input  stall, flush, in_valid, offset, ext_op,
    output out_valid, sign_imm, out_op, op_err
  );
endinterface

// File: rtl/d_ext_pipe.sv
// d_ext_pipe: immediate extender with registered D->E output; EXT_BYTE_EN adds byte sign/zero-extend ops 5/6
module d_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  d_ext_pipe_if.slave bus
);
  localparam int E = OUT_W - IN_W;
  if (OUT_W < IN_W + 2) begin : g_width_chk
    $error("d_ext_pipe: OUT_W must be at least IN_W+2");
  end
  logic [OUT_W-1:0] zext, sext, lui, broff, shamt, result;
  logic [4:0]       sh5;
  logic             rsvd;
  if (IN_W >= 11) begin : g_sh
    assign sh5 = bus.offset[10:6];
  end else begin : g_sh
    assign sh5 = bus.offset[IN_W-1:IN_W-5];
  end
  assign zext  = {{E{1'b0}}, bus.offset};
  assign sext  = {{E{bus.offset[IN_W-1]}}, bus.offset};
  assign lui   = {bus.offset, {E{1'b0}}};
  assign broff = {sext[OUT_W-3:0], 2'b00};
  assign shamt = {{(OUT_W-5){1'b0}}, sh5};
`ifdef EXT_BYTE_EN
  logic [OUT_W-1:0] sbyte, zbyte;
  assign sbyte = {{(OUT_W-8){bus.offset[7]}}, bus.offset[7:0]};
  assign zbyte = {{(OUT_W-8){1'b0}}, bus.offset[7:0]};
  assign rsvd  = bus.ext_op == 3'd7;
  always_comb
    result = bus.ext_op == 3'd0 ? zext  :
             bus.ext_op == 3'd1 ? sext  :
             bus.ext_op == 3'd2 ? lui   :
             bus.ext_op == 3'd3 ? broff :
             bus.ext_op == 3'd4 ? shamt :
             bus.ext_op == 3'd5 ? sbyte :
             bus.ext_op == 3'd6 ? zbyte : '0;
`else
  assign rsvd = bus.ext_op > 3'd4;
  always_comb
    result = bus.ext_op == 3'd0 ? zext  :
             bus.ext_op == 3'd1 ? sext  :
             bus.ext_op == 3'd2 ? lui   :
             bus.ext_op == 3'd3 ? broff :
             bus.ext_op == 3'd4 ? shamt : '0;
`endif
  // op_err only latches on edges that actually load the register
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.sign_imm  <= '0;
      bus.out_op    <= '0;
      bus.op_err    <= 1'b0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
      bus.sign_imm  <= '0;
      bus.out_op    <= '0;
    end else if (!bus.stall) begin
      bus.out_valid <= bus.in_valid;
      bus.sign_imm  <= result;
      bus.out_op    <= bus.ext_op;
      bus.op_err    <= bus.op_err | (bus.in_valid & rsvd);
    end
endmodule

// File: tb/tb_d_ext_pipe.sv
// tb_d_ext_pipe: directed and random stimulus for d_ext_pipe against an arithmetic reference model
module tb_d_ext_pipe;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  d_ext_pipe_if #(.IN_W(16), .OUT_W(32)) bus ();
  d_ext_pipe #(.IN_W(16), .OUT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
`ifdef EXT_BYTE_EN
  localparam bit BYTE = 1'b1;
`else
  localparam bit BYTE = 1'b0;
`endif
  int total = 0;
  int bad = 0;
  logic        m_valid, m_err;
  logic [31:0] m_imm;
  logic [2:0]  m_op;
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [15:0] off);
    int s, s8;
    s  = int'($signed(off));
    s8 = int'($signed(off[7:0]));
    case (op)
      3'd0: return 32'(int'(off));
      3'd1: return 32'(s);
      3'd2: return 32'(int'(off) * 65536);
      3'd3: return 32'(s * 4);
      3'd4: return 32'((int'(off) / 64) % 32);
      3'd5: return BYTE ? 32'(s8) : 32'd0;
      3'd6: return BYTE ? 32'(int'(off) % 256) : 32'd0;
      default: return 32'd0;
    endcase
  endfunction
  function automatic bit is_rsvd(input logic [2:0] op);
    return op == 3'd7 || (!BYTE && (op == 3'd5 || op == 3'd6));
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, m_valid});
    chk({tag, ".sign_imm"}, bus.sign_imm, m_imm);
    chk({tag, ".out_op"}, {29'd0, bus.out_op}, {29'd0, m_op});
    chk({tag, ".op_err"}, {31'd0, bus.op_err}, {31'd0, m_err});
  endtask
  task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] off,
                       input logic st, input logic fl);
    bus.in_valid = v;
    bus.ext_op   = op;
    bus.offset   = off;
    bus.stall    = st;
    bus.flush    = fl;
  endtask
  task automatic clear_model();
    m_valid = 1'b0;
    m_imm   = 32'd0;
    m_op    = 3'd0;
    m_err   = 1'b0;
  endtask
  task automatic tick(input string tag);
    @(posedge clk);
    if (bus.flush) begin
      m_valid = 1'b0;
      m_imm   = 32'd0;
      m_op    = 3'd0;
    end else if (!bus.stall) begin
      m_valid = bus.in_valid;
      m_imm   = ref_res(bus.ext_op, bus.offset);
      m_op    = bus.ext_op;
      m_err   = m_err | (bus.in_valid && is_rsvd(bus.ext_op));
    end
    #1 check_all(tag);
  endtask
  initial begin
    drive(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    clear_model();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) reset = 1'b0;
    drive(1'b1, 3'd0, 16'h1234, 1'b0, 1'b0);
    tick("load1234");
    #2 reset = 1'b1;
    clear_model();
    #1 check_all("async_reset");
    #1 reset = 1'b0;
    drive(1'b1, 3'd0, 16'h8001, 1'b0, 1'b0); tick("zero");
    drive(1'b1, 3'd1, 16'h8001, 1'b0, 1'b0); tick("sign");
    drive(1'b1, 3'd2, 16'h8001, 1'b0, 1'b0); tick("lui");
    drive(1'b1, 3'd3, 16'hFFFF, 1'b0, 1'b0); tick("broff_neg");
    drive(1'b1, 3'd3, 16'h7FFF, 1'b0, 1'b0); tick("broff_pos");
    drive(1'b1, 3'd4, 16'h0140, 1'b0, 1'b0); tick("shamt");
    chk("shamt_const", bus.sign_imm, 32'h5);
    drive(1'b1, 3'd0, 16'h0010, 1'b0, 1'b0); tick("pre_stall");
    drive(1'b1, 3'd1, 16'hFFFF, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick("stall_hold");
    chk("stall_const", bus.sign_imm, 32'h10);
    drive(1'b1, 3'd1, 16'hFFFF, 1'b0, 1'b0); tick("stall_release");
    chk("release_const", bus.sign_imm, 32'hFFFFFFFF);
    drive(1'b1, 3'd1, 16'h1234, 1'b1, 1'b1); tick("stall_flush");
    drive(1'b1, 3'd7, 16'h5555, 1'b0, 1'b1); tick("flush_rsvd");
    chk("flush_no_err", {31'd0, bus.op_err}, 32'd0);
    drive(1'b0, 3'd7, 16'h5555, 1'b0, 1'b0); tick("bubble_rsvd");
    drive(1'b1, 3'd5, 16'h0080, 1'b0, 1'b0); tick("byte_op5");
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'($urandom_range(0, 4)), 16'($urandom), 1'b0, 1'b0);
      tick("legal_after_5");
    end
    drive(1'b1, 3'd6, 16'h00F0, 1'b0, 1'b0); tick("byte_op6");
    reset = 1'b1;
    clear_model();
    #1 check_all("reset2");
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 16'($urandom),
            1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0));
      tick("random");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/d_ext_pipe.md
Name: d_ext_pipe

Overview:
- Parametrised decode-stage immediate extender with a registered D→E pipeline output.
- Supports zero-extend, sign-extend, LUI placement, branch-offset (sign-extend then shift left by 2), and shift-amount modes.
- Result is captured into an output register that honours pipeline stall and flush, and carries a valid bit.
- Sits between the D-stage decoder and the E-stage ALU/branch-target adder; replaces the single-bit-op combinational extender.

Parameters:
- IN_W, 16, width of the immediate field taken from the instruction.
- OUT_W, 32, width of the extended result; legal only if OUT_W >= IN_W+2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold the output register (D/E stall from the hazard unit).
- flush  input  1  bubble the output register; has priority over stall.
- in_valid  input  1  D stage holds a real instruction this cycle.
- offset  input  IN_W  raw immediate field.
- ext_op  input  3  extension mode (encoding under Behaviour).
- out_valid  output  1  registered: sign_imm holds a real result.
- sign_imm  output  OUT_W  registered extended immediate.
- out_op  output  3  registered copy of the ext_op that produced sign_imm.
- op_err  output  1  sticky flag: a reserved ext_op was accepted while in_valid=1.

Behaviour:
- Reset (async, any time, including mid-stall): out_valid=0, sign_imm=0, out_op=0, op_err=0. Takes effect immediately, independent of clk.
- ext_op encoding, computed combinationally from offset:
  - 0 ZERO: {(OUT_W-IN_W) zeros, offset}.
  - 1 SIGN: {(OUT_W-IN_W) copies of offset[IN_W-1], offset}.
  - 2 LUI: {offset, (OUT_W-IN_W) zeros}; when IN_W=16 and OUT_W=32 this equals offset<<16.
  - 3 BROFF: SIGN result shifted left 2, low two bits 0; upper bits dropped to OUT_W.
  - 4 SHAMT: zero-extend offset[10:6]; for IN_W<11 use offset[IN_W-1:IN_W-5].
  - 5, 6: see Optional Feature.
  - 7: reserved.
- Reserved op result value is 0.
- Clock edge update, highest priority first:
  - flush=1: out_valid←0, sign_imm←0, out_op←0.
  - else stall=1: all outputs hold.
  - else: out_valid←in_valid, sign_imm←result, out_op←ext_op.
- Latency: exactly 1 cycle from D inputs to outputs when neither stall nor flush is asserted.
- in_valid=0 in a normal cycle still loads the result, but out_valid=0 marks it a bubble; consumers ignore sign_imm when out_valid=0.
- op_err:
  - Set on any non-stalled, non-flushed edge where in_valid=1 and ext_op is reserved.
  - Set only when the register actually loads.
  - Once set, stays set until reset.
- Simultaneous stall+flush: flush wins; the output becomes a bubble.
- Arithmetic is purely bit placement and replication; there is no overflow flag.
- Elaboration check: OUT_W < IN_W+2 must cause a generate-time error.

Optional Feature:
- Macro: EXT_BYTE_EN.
- Defined:
  - ext_op 5 = sign-extend offset[7:0] to OUT_W.
  - ext_op 6 = zero-extend offset[7:0] to OUT_W.
  - Neither mode sets op_err.
- Undefined: ext_op 5 and 6 are reserved, produce 0, and set op_err like ext_op 7.

Test Plan:
- Reset asserted mid-cycle with out_valid=1, sign_imm=0x1234 → all outputs 0 immediately, before the next clk edge.
- offset=0x8001, in_valid=1: ext_op=0 → 0x00008001; ext_op=1 → 0xFFFF8001; ext_op=2 → 0x80010000, each one cycle later with out_valid=1.
- offset=0xFFFF, ext_op=3 → 0xFFFFFFFC; offset=0x7FFF, ext_op=3 → 0x0001FFFC; offset=0x0140, ext_op=4 → 0x00000005.
- Load 0x00000010, then stall=1 for 3 cycles while the inputs change to 0xFFFF/SIGN → output stays 0x00000010; on release → 0xFFFFFFFF.
- stall=1 and flush=1 together → out_valid=0, sign_imm=0; a second case with ext_op=7, in_valid=1, flush=1 → op_err stays 0.
- ext_op=5, offset=0x0080: with EXT_BYTE_EN → 0xFFFFFF80, op_err=0; without EXT_BYTE_EN → 0x00000000, op_err=1, still 1 after 5 further legal ops.
